reg_read_unit: RTL and testbench
================================

Name: reg_read_unit

Overview:
- Read-side companion to the processor register storage array.
- Accepts a read request for two source registers over a valid/ready handshake and returns both operands one cycle later in a registered response slot.
- Forwards a same-cycle writeback and keeps a pending-write scoreboard, so it stalls any request whose source register still has an outstanding writer.
- Sits between decode and execute; `regs` comes straight from the storage block's flat register-array output.

Parameters:
- reg_size, 32, data width of one register in bits
- mem_size, 32, number of registers
- ZERO_REG, 1, when 1: index 0 always reads 0, never becomes busy, and ignores writebacks
- AW, $clog2(mem_size), address width (derived; not overridden)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- regs  in  [mem_size-1:0][reg_size-1:0]  current contents of register storage
- req_valid  in  1  read request present
- req_ready  out  1  unit accepts request this cycle
- req_rs1  in  AW  first source index
- req_rs2  in  AW  second source index
- req_rd  in  AW  destination index of the issuing instruction
- req_rd_we  in  1  issuing instruction will write req_rd
- wb_valid  in  1  writeback to storage happens this cycle
- wb_addr  in  AW  writeback index
- wb_data  in  reg_size  writeback value
- rsp_valid  out  1  operands available
- rsp_ready  in  1  consumer takes operands
- rsp_rs1_data  out  reg_size  operand 1
- rsp_rs2_data  out  reg_size  operand 2
- idle  out  1  scoreboard empty and rsp_valid=0

Behaviour:
- Reset (rst_n=0 at clk edge): busy[] all 0, rsp_valid=0, rsp_rs1_data=0, rsp_rs2_data=0. Reset overrides every other event, including one mid-handshake; any held response is dropped.
- Scoreboard: busy[mem_size], 1 bit per register.
  - busy[i] is set on accept when req_rd_we=1 and req_rd=i.
  - busy[i] is cleared when wb_valid=1 and wb_addr=i.
  - If set and clear hit the same index in the same cycle, set wins, because the new writer is younger.
- Hazard for source s: busy[s]=1 AND NOT (wb_valid AND wb_addr=s). With ZERO_REG=1, s=0 is never a hazard.
- Slot free: rsp_valid=0 OR rsp_ready=1.
- req_ready = slot free AND no hazard on rs1 AND no hazard on rs2. It is combinational and does not depend on req_valid.
- Accept = req_valid AND req_ready.
- Operand select, per source:
  - with ZERO_REG=1 and index 0: the value is 0;
  - else if wb_valid AND wb_addr=index: the value is wb_data (forward);
  - else: the value is regs[index].
- Latency: exactly 1 cycle. On accept, the operands are registered and rsp_valid=1 on the next cycle.
- Hold: while rsp_valid=1 and rsp_ready=0, data and rsp_valid are stable.
- Drain: if rsp_ready=1 and there is no accept, rsp_valid goes to 0 next cycle.
- Back-to-back: with a response leaving and a new request accepted in the same cycle, one response per cycle is sustained.
- req_rd equal to req_rs1 or req_rs2 is legal: the old value is read, then busy is set.
- A writeback to a non-busy index only has its forwarding effect; it is not an error.
- Writeback to index 0 with ZERO_REG=1 is ignored for both forwarding and the scoreboard.
- idle is combinational: (busy == 0) AND rsp_valid=0.

Test Plan:
- Reset, then regs[3]=0xA5, regs[7]=0x11; request rs1=3, rs2=7, rsp_ready=1 -> next cycle rsp_valid=1, data 0xA5 / 0x11; the cycle after, rsp_valid=0 and idle=1.
- Request rd=5 with rd_we=1, then rs1=5 -> req_ready=0 until wb_valid with wb_addr=5 and wb_data=0xDEAD. In that cycle the request is accepted and rsp_rs1_data=0xDEAD, even though regs[5] is still old.
- rsp_ready=0 for 3 cycles with a new req_valid pending -> req_ready=0, response held unchanged; when rsp_ready=1 the next request is accepted in the same cycle.
- Same cycle: accept with rd=9, rd_we=1 and wb_valid with wb_addr=9 -> busy[9]=1 afterward; a following read of 9 stalls.
- ZERO_REG=1: regs[0]=0xFFFF, request rd=0 with rd_we, then rs1=0, rs2=0 -> no stall, both operands 0.
- Assert rst_n=0 while rsp_valid=1 and busy[4]=1 -> next cycle rsp_valid=0, idle=1, and a read of 4 is accepted immediately.

Source files
------------

// File: rtl/reg_read_unit.sv
// Register read unit: two-operand read with writeback forwarding,
// a pending-write scoreboard and a one-entry registered response slot.
module reg_read_unit #(
    parameter int unsigned reg_size = 32,
    parameter int unsigned mem_size = 32,
    parameter bit          ZERO_REG = 1'b1,
    parameter int unsigned AW       = $clog2(mem_size)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [mem_size-1:0][reg_size-1:0]  regs,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [AW-1:0]                      req_rs1,
    input  logic [AW-1:0]                      req_rs2,
    input  logic [AW-1:0]                      req_rd,
    input  logic                               req_rd_we,
    input  logic                               wb_valid,
    input  logic [AW-1:0]                      wb_addr,
    input  logic [reg_size-1:0]                wb_data,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [reg_size-1:0]                rsp_rs1_data,
    output logic [reg_size-1:0]                rsp_rs2_data,
    output logic                               idle
);

    logic [mem_size-1:0] busy_q, busy_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [reg_size-1:0] rs1_data_q, rs1_data_d;
    logic [reg_size-1:0] rs2_data_q, rs2_data_d;

    logic rs1_zero, rs2_zero, rd_zero, wb_zero;
    logic wb_en;
    logic fwd_rs1, fwd_rs2;
    logic haz_rs1, haz_rs2;
    logic slot_free;
    logic accept;
    logic [reg_size-1:0] op1, op2;

    assign rs1_zero = ZERO_REG && (req_rs1 == '0);
    assign rs2_zero = ZERO_REG && (req_rs2 == '0);
    assign rd_zero  = ZERO_REG && (req_rd == '0);
    assign wb_zero  = ZERO_REG && (wb_addr == '0);

    // A hardwired-zero writeback neither forwards nor touches the scoreboard
    assign wb_en   = wb_valid && !wb_zero;
    assign fwd_rs1 = wb_en && (wb_addr == req_rs1);
    assign fwd_rs2 = wb_en && (wb_addr == req_rs2);

    assign haz_rs1 = busy_q[req_rs1] && !fwd_rs1 && !rs1_zero;
    assign haz_rs2 = busy_q[req_rs2] && !fwd_rs2 && !rs2_zero;

    assign slot_free = !rsp_valid_q || rsp_ready;
    assign req_ready = slot_free && !haz_rs1 && !haz_rs2;
    assign accept    = req_valid && req_ready;

    always_comb begin
        op1 = regs[req_rs1];
        if (rs1_zero) begin
            op1 = '0;
        end else if (fwd_rs1) begin
            op1 = wb_data;
        end
    end

    always_comb begin
        op2 = regs[req_rs2];
        if (rs2_zero) begin
            op2 = '0;
        end else if (fwd_rs2) begin
            op2 = wb_data;
        end
    end

    // Set after clear: a newly accepted writer is younger than the retiring one
    always_comb begin
        busy_d = busy_q;
        if (wb_en) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (accept && req_rd_we && !rd_zero) begin
            busy_d[req_rd] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rs1_data_d  = op1;
            rs2_data_d  = op2;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q      <= '0;
            rsp_valid_q <= 1'b0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
        end else begin
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_rs1_data = rs1_data_q;
    assign rsp_rs2_data = rs2_data_q;
    assign idle         = (busy_q == '0) && !rsp_valid_q;

endmodule

// File: tb/tb_reg_read_unit.sv
// Bench for reg_read_unit: directed scenarios plus randomized traffic
// checked against a scoreboard-level reference model.
module tb_reg_read_unit;

    localparam int RS = 32;
    localparam int MS = 32;
    localparam int AW = 5;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [MS-1:0][RS-1:0]    regs;
    logic                     req_valid;
    logic                     req_ready;
    logic [AW-1:0]            req_rs1, req_rs2, req_rd;
    logic                     req_rd_we;
    logic                     wb_valid;
    logic [AW-1:0]            wb_addr;
    logic [RS-1:0]            wb_data;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [RS-1:0]            rsp_rs1_data, rsp_rs2_data;
    logic                     idle;

    always #5 clk = ~clk;

    reg_read_unit #(
        .reg_size(RS),
        .mem_size(MS),
        .ZERO_REG(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .regs(regs),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_rs1(req_rs1),
        .req_rs2(req_rs2),
        .req_rd(req_rd),
        .req_rd_we(req_rd_we),
        .wb_valid(wb_valid),
        .wb_addr(wb_addr),
        .wb_data(wb_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rs1_data(rsp_rs1_data),
        .rsp_rs2_data(rsp_rs2_data),
        .idle(idle)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: set of registers with an outstanding writer,
    // plus the single response held for the consumer.
    bit [MS-1:0] m_busy;
    bit          m_vld;
    logic [RS-1:0] m_d1, m_d2;

    function automatic bit hz(logic [AW-1:0] s);
        if (s == 0) return 1'b0;
        return m_busy[s] && !(wb_valid && wb_addr == s);
    endfunction

    function automatic logic [RS-1:0] opnd(logic [AW-1:0] s);
        if (s == 0) return '0;
        if (wb_valid && wb_addr == s) return wb_data;
        return regs[s];
    endfunction

    function automatic bit exp_ready();
        return (!m_vld || rsp_ready) && !hz(req_rs1) && !hz(req_rs2);
    endfunction

    task automatic model_step();
        bit acc;
        bit [MS-1:0] nb;
        if (!rst_n) begin
            m_busy = '0;
            m_vld  = 1'b0;
            m_d1   = '0;
            m_d2   = '0;
            return;
        end
        acc = req_valid && exp_ready();
        nb  = m_busy;
        if (wb_valid && wb_addr != 0) nb[wb_addr] = 1'b0;
        if (acc && req_rd_we && req_rd != 0) nb[req_rd] = 1'b1;
        if (acc) begin
            m_vld = 1'b1;
            m_d1  = opnd(req_rs1);
            m_d2  = opnd(req_rs2);
        end else if (rsp_ready) begin
            m_vld = 1'b0;
        end
        m_busy = nb;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        req_valid = 1'b0;
        req_rs1   = '0;
        req_rs2   = '0;
        req_rd    = '0;
        req_rd_we = 1'b0;
        wb_valid  = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        rsp_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        quiet();
        for (int i = 0; i < MS; i++) regs[i] = $urandom;
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b expected 0", rsp_valid);
        end
        n_checks++;
        if (rsp_rs1_data !== 32'h0 || rsp_rs2_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h expected 0/0",
                     rsp_rs1_data, rsp_rs2_data);
        end
        n_checks++;
        if (idle !== 1'b1 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_idle: got idle=%b ready=%b expected 1/1",
                     idle, req_ready);
        end
    endtask

    task automatic test_basic();
        regs[3]   = 32'hA5;
        regs[7]   = 32'h11;
        req_valid = 1'b1;
        req_rs1   = 5'd3;
        req_rs2   = 5'd7;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_ready: got %b expected 1", req_ready);
        end
        cyc();
        quiet();
        #1;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_rs1_data !== 32'hA5 ||
            rsp_rs2_data !== 32'h11) begin
            n_fail++;
            $display("FAIL basic_rsp: got v=%b %h/%h expected 1 a5/11",
                     rsp_valid, rsp_rs1_data, rsp_rs2_data);
        end
        cyc();
        n_checks++;
        if (rsp_valid !== 1'b0 || idle !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_drain: got v=%b idle=%b expected 0/1",
                     rsp_valid, idle);
        end
    endtask

    task automatic test_forward_stall();
        regs[5]   = 32'h1234;
        req_valid = 1'b1;
        req_rd    = 5'd5;
        req_rd_we = 1'b1;
        cyc();
        req_rd_we = 1'b0;
        req_rd    = '0;
        req_rs1   = 5'd5;
        req_rs2   = '0;
        #1;
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_stall1: got %b expected 0", req_ready);
        end
        cyc();
        n_checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_stall2: got ready=%b v=%b expected 0/0",
                     req_ready, rsp_valid);
        end
        wb_valid = 1'b1;
        wb_addr  = 5'd5;
        wb_data  = 32'hDEAD;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fwd_release: got %b expected 1", req_ready);
        end
        cyc();
        quiet();
        #1;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_rs1_data !== 32'hDEAD ||
            idle !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_data: got v=%b %h idle=%b expected 1 dead 0",
                     rsp_valid, rsp_rs1_data, idle);
        end
        cyc();
        n_checks++;
        if (idle !== 1'b1) begin
            n_fail++;
            $display("FAIL fwd_idle: got %b expected 1", idle);
        end
    endtask

    task automatic test_hold();
        regs[1]   = 32'h1111_0001;
        regs[2]   = 32'h2222_0002;
        regs[10]  = 32'hAAAA_000A;
        regs[11]  = 32'hBBBB_000B;
        req_valid = 1'b1;
        req_rs1   = 5'd1;
        req_rs2   = 5'd2;
        cyc();
        rsp_ready = 1'b0;
        req_rs1   = 5'd10;
        req_rs2   = 5'd11;
        regs[1]   = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b1 ||
                rsp_rs1_data !== 32'h1111_0001 ||
                rsp_rs2_data !== 32'h2222_0002) begin
                n_fail++;
                $display("FAIL hold_%0d: got r=%b v=%b %h/%h expected 0 1 11110001/22220002",
                         i, req_ready, rsp_valid, rsp_rs1_data, rsp_rs2_data);
            end
            cyc();
        end
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release: got %b expected 1", req_ready);
        end
        cyc();
        quiet();
        #1;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_rs1_data !== 32'hAAAA_000A ||
            rsp_rs2_data !== 32'hBBBB_000B) begin
            n_fail++;
            $display("FAIL hold_next: got v=%b %h/%h expected 1 aaaa000a/bbbb000b",
                     rsp_valid, rsp_rs1_data, rsp_rs2_data);
        end
        cyc();
    endtask

    task automatic test_set_clear();
        req_valid = 1'b1;
        req_rd    = 5'd9;
        req_rd_we = 1'b1;
        cyc();
        wb_valid = 1'b1;
        wb_addr  = 5'd9;
        wb_data  = 32'h99;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL setclr_accept: got %b expected 1", req_ready);
        end
        cyc();
        quiet();
        req_valid = 1'b1;
        req_rs1   = 5'd9;
        #1;
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL setclr_stall: got %b expected 0", req_ready);
        end
        cyc();
        wb_valid = 1'b1;
        wb_addr  = 5'd9;
        wb_data  = 32'h77;
        cyc();
        quiet();
        #1;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_rs1_data !== 32'h77) begin
            n_fail++;
            $display("FAIL setclr_fwd: got v=%b %h expected 1 77",
                     rsp_valid, rsp_rs1_data);
        end
        cyc();
    endtask

    task automatic test_zero_reg();
        regs[0]   = 32'hFFFF;
        req_valid = 1'b1;
        req_rd    = '0;
        req_rd_we = 1'b1;
        cyc();
        req_rd_we = 1'b0;
        wb_valid  = 1'b1;
        wb_addr   = '0;
        wb_data   = 32'h77;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_ready: got %b expected 1", req_ready);
        end
        cyc();
        quiet();
        #1;
        n_checks++;
        if (rsp_rs1_data !== 32'h0 || rsp_rs2_data !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_data: got %h/%h expected 0/0",
                     rsp_rs1_data, rsp_rs2_data);
        end
        cyc();
        n_checks++;
        if (idle !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_idle: got %b expected 1", idle);
        end
    endtask

    task automatic test_back_to_back();
        logic [RS-1:0] v [4];
        for (int i = 0; i < 4; i++) begin
            v[i]          = $urandom | 32'h1;
            regs[12 + i]  = v[i];
        end
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_rs1 = AW'(12 + i);
            req_rs2 = AW'(15 - i);
            #1;
            n_checks++;
            if (req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready_%0d: got %b expected 1", i, req_ready);
            end
            cyc();
            #1;
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_rs1_data !== v[i] ||
                rsp_rs2_data !== v[3 - i]) begin
                n_fail++;
                $display("FAIL b2b_rsp_%0d: got v=%b %h/%h expected 1 %h/%h",
                         i, rsp_valid, rsp_rs1_data, rsp_rs2_data,
                         v[i], v[3 - i]);
            end
        end
        quiet();
        cyc();
    endtask

    task automatic test_reset_mid();
        regs[4]   = 32'h4444;
        req_valid = 1'b1;
        req_rd    = 5'd4;
        req_rd_we = 1'b1;
        cyc();
        quiet();
        rsp_ready = 1'b0;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b1 || idle !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_pre: got v=%b idle=%b expected 1/0",
                     rsp_valid, idle);
        end
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || idle !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_post: got v=%b idle=%b expected 0/1",
                     rsp_valid, idle);
        end
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_rs1   = 5'd4;
        req_rs2   = 5'd4;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_ready: got %b expected 1", req_ready);
        end
        cyc();
        quiet();
        #1;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_rs1_data !== 32'h4444) begin
            n_fail++;
            $display("FAIL rstmid_rsp: got v=%b %h expected 1 4444",
                     rsp_valid, rsp_rs1_data);
        end
        cyc();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            req_valid = 1'($urandom);
            req_rs1   = AW'($urandom_range(0, 7));
            req_rs2   = AW'($urandom_range(0, 7));
            req_rd    = AW'($urandom_range(0, 7));
            req_rd_we = 1'($urandom);
            wb_valid  = ($urandom_range(0, 2) == 0);
            wb_addr   = AW'($urandom_range(0, 7));
            wb_data   = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, 7)] = $urandom;
            #1;
            n_checks++;
            if (req_ready !== exp_ready()) begin
                n_fail++;
                $display("FAIL rnd_ready @%0d: got %b expected %b",
                         n, req_ready, exp_ready());
            end
            n_checks++;
            if (rsp_valid !== m_vld) begin
                n_fail++;
                $display("FAIL rnd_valid @%0d: got %b expected %b",
                         n, rsp_valid, m_vld);
            end
            n_checks++;
            if (rsp_rs1_data !== m_d1 || rsp_rs2_data !== m_d2) begin
                n_fail++;
                $display("FAIL rnd_data @%0d: got %h/%h expected %h/%h",
                         n, rsp_rs1_data, rsp_rs2_data, m_d1, m_d2);
            end
            n_checks++;
            if (idle !== (m_busy == '0 && !m_vld)) begin
                n_fail++;
                $display("FAIL rnd_idle @%0d: got %b expected %b",
                         n, idle, (m_busy == '0 && !m_vld));
            end
            cyc();
        end
        rst_n = 1'b1;
        quiet();
    endtask

    initial begin
        m_busy = '0;
        m_vld  = 1'b0;
        m_d1   = '0;
        m_d2   = '0;
        test_reset();
        test_basic();
        test_forward_stall();
        test_hold();
        test_set_clear();
        test_zero_reg();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
